rank_filter: RTL and testbench

//  Parametrised serial rank-order filter; generalises MEDIAN to any window size N, pixel width W and a runtime-selectable rank.

---
 rtl/rank_filter_pkg.sv | 15 +
 rtl/rank_sorter.sv | 69 ++++++
 rtl/rank_filter.sv | 121 ++++++++++++
 tb/tb_rank_filter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// rtl/rank_filter_pkg.sv - shared types and helpers for the rank-order filter
package rank_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Rank port width; never narrower than one bit, so small windows still get a port
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rank_sorter.sv
// rtl/rank_sorter.sv - descending insertion-sorted sample array with valid bits
module rank_sorter
#(
    parameter int W = 8,
    parameter int N = 9
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr_ins,
    input  logic           ins,
    input  logic [W-1:0]   x,
    output logic [N*W-1:0] s_flat
);

    logic [W-1:0] s_q [N];
    logic [W-1:0] s_d [N];
    logic [N-1:0] v_q;
    logic [N-1:0] v_d;
    logic [N-1:0] c;

    // Per-slot compare: an empty slot is -infinity, equal values stay ahead of x
    always_comb begin
        c = '0;
        for (int i = 0; i < N; i++) begin
            c[i] = !v_q[i] || (x > s_q[i]);
        end
    end

    // Next array: restart with x alone, or shift the tail down one slot and drop x in the gap
    always_comb begin
        s_d = s_q;
        v_d = v_q;
        if (clr_ins) begin
            v_d    = '0;
            v_d[0] = 1'b1;
            s_d[0] = x;
        end else if (ins) begin
            if (c[0]) begin
                s_d[0] = x;
                v_d[0] = 1'b1;
            end
            for (int i = 1; i < N; i++) begin
                if (c[i]) begin
                    s_d[i] = c[i-1] ? s_q[i-1] : x;
                    v_d[i] = c[i-1] ? v_q[i-1] : 1'b1;
                end
            end
        end
    end

    // Array and valid-bit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                s_q[i] <= '0;
            end
            v_q <= '0;
        end else begin
            s_q <= s_d;
            v_q <= v_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign s_flat[g*W +: W] = s_q[g];
    end

endmodule

// File: rtl/rank_filter.sv
// rtl/rank_filter.sv - serial rank-order filter (median/max/min over an N-sample burst)
module rank_filter
    import rank_filter_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 9,
    localparam int RW = clog2_min1(N)
)
(
    input  logic          CLK,
    input  logic          nRST,
    input  logic [W-1:0]  DI,
    input  logic          DSI,
    input  logic [RW-1:0] RANK,
    output logic [W-1:0]  DO,
    output logic          DSO,
    output logic          ERR
);

    localparam logic [RW:0] N_C = (RW+1)'(N);
    localparam logic [RW:0] ONE = (RW+1)'(1);

    state_t          state_q, state_d;
    logic [RW:0]     count_q, count_d;
    logic [RW-1:0]   rank_q, rank_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    do_q, do_d;
    logic            dso_q, dso_d;
    logic            err_q, err_d;
    logic            clr_ins;
    logic            ins;
    logic [N*W-1:0]  s_flat;
    logic [RW:0]     eff_rank;
    logic [RW:0]     sel;

    rank_sorter #(.W(W), .N(N)) u_sorter (
        .clk     (CLK),
        .rst_n   (nRST),
        .clr_ins (clr_ins),
        .ins     (ins),
        .x       (DI),
        .s_flat  (s_flat)
    );

    // Clamp the rank to the window, then to the number of samples actually held
    always_comb begin
        eff_rank = ({1'b0, rank_q} >= N_C) ? (N_C - ONE) : {1'b0, rank_q};
        sel      = (eff_rank > (count_q - ONE)) ? (count_q - ONE) : eff_rank;
    end

    // Burst sequencing, sorter control and result selection
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rank_d  = rank_q;
        ovf_d   = ovf_q;
        do_d    = do_q;
        dso_d   = 1'b0;
        err_d   = err_q;
        clr_ins = 1'b0;
        ins     = 1'b0;
        case (state_q)
            LOAD: begin
                if (DSI) begin
                    if (count_q < N_C) begin
                        ins     = 1'b1;
                        count_d = count_q + ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (sel == (RW+1)'(i)) begin
                            do_d = s_flat[i*W +: W];
                        end
                    end
                    err_d   = (count_q != N_C) || ovf_q;
                    dso_d   = 1'b1;
                    state_d = OUT;
                end
            end
            default: begin
                if (DSI) begin
                    clr_ins = 1'b1;
                    count_d = ONE;
                    rank_d  = RANK;
                    ovf_d   = 1'b0;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            count_q <= '0;
            rank_q  <= '0;
            ovf_q   <= 1'b0;
            do_q    <= '0;
            dso_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rank_q  <= rank_d;
            ovf_q   <= ovf_d;
            do_q    <= do_d;
            dso_q   <= dso_d;
            err_q   <= err_d;
        end
    end

    assign DO  = do_q;
    assign DSO = dso_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_rank_filter.sv
// tb/tb_rank_filter.sv - randomized and directed checks of rank_filter against a sort-based model
module tb_rank_filter;

    localparam int W  = 8;
    localparam int N  = 9;
    localparam int RW = 4;
    localparam int IMG = 12;

    logic          clk  = 1'b0;
    logic          nrst = 1'b0;
    logic          dsi  = 1'b0;
    logic [W-1:0]  di   = '0;
    logic [RW-1:0] rank = '0;
    logic [W-1:0]  do_o;
    logic          dso;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rank_filter #(.W(W), .N(N)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .DI   (di),
        .DSI  (dsi),
        .RANK (rank),
        .DO   (do_o),
        .DSO  (dso),
        .ERR  (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect the burst, keep the first N, sort descending, pick the clamped rank
    logic [W-1:0] m_kept[$];
    logic [W-1:0] m_sorted[$];
    int           m_total = 0;
    int           m_rank  = 0;
    bit           m_in    = 0;
    logic [W-1:0] exp_do  = '0;
    bit           exp_dso = 0;
    bit           exp_err = 0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_kept.delete();
            m_total = 0;
            m_in    = 0;
            exp_do  = '0;
            exp_dso = 0;
            exp_err = 0;
        end else begin
            exp_dso = 0;
            if (dsi) begin
                if (!m_in) begin
                    m_kept.delete();
                    m_total = 0;
                    m_rank  = int'(rank);
                    m_in    = 1;
                end
                if (m_kept.size() < N) m_kept.push_back(di);
                m_total++;
            end else if (m_in) begin
                int r;
                m_sorted = m_kept;
                m_sorted.rsort();
                r = m_rank;
                if (r > N - 1) r = N - 1;
                if (r > m_sorted.size() - 1) r = m_sorted.size() - 1;
                exp_do  = m_sorted[r];
                exp_err = (m_total != N);
                exp_dso = 1;
                m_in    = 0;
            end
        end
    end

    // Every cycle: strobe, held result and error flag must match the model
    always @(negedge clk) begin
        check("dso", 32'(dso), 32'(exp_dso));
        check("do",  32'(do_o), 32'(exp_do));
        check("err", 32'(err), 32'(exp_err));
    end

    // Drive a burst starting at the current negedge; returns at the negedge inside the DSO cycle
    task automatic run_burst(input logic [W-1:0] s[$], input int r, input int lit_do, input int lit_err);
        foreach (s[i]) begin
            dsi  = 1'b1;
            di   = s[i];
            rank = (i == 0) ? r[RW-1:0] : RW'($urandom);
            @(negedge clk);
        end
        dsi = 1'b0;
        di  = W'($urandom);
        @(negedge clk);
        if (lit_do >= 0) begin
            check("lit_dso", 32'(dso), 32'd1);
            check("lit_do",  32'(do_o), 32'(lit_do));
            check("lit_err", 32'(err), 32'(lit_err));
        end
    endtask

    logic [W-1:0] b1[$];
    logic [W-1:0] b2[$];
    logic [W-1:0] bs[$];
    logic [W-1:0] bl[$];
    logic [W-1:0] br[$];
    logic [W-1:0] img [IMG][IMG];

    initial begin
        b1 = '{8'd12, 8'd200, 8'd7, 8'd55, 8'd55, 8'd3, 8'd90, 8'd128, 8'd1};
        b2 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        bs = '{8'd10, 8'd40, 8'd20, 8'd30, 8'd50};
        bl = b1;
        bl.push_back(8'd255);
        bl.push_back(8'd0);

        repeat (2) @(negedge clk);
        check("rst_dso", 32'(dso), 32'd0);
        check("rst_do",  32'(do_o), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        #1 nrst = 1'b1;
        @(negedge clk);

        run_burst(b1, 4, 55, 0);   repeat (2) @(negedge clk);
        run_burst(b1, 0, 200, 0);  @(negedge clk);
        run_burst(b1, 8, 1, 0);    @(negedge clk);
        run_burst(b1, 15, 1, 0);   @(negedge clk);
        run_burst(bs, 6, 10, 1);   @(negedge clk);
        run_burst(bl, 4, 55, 1);   @(negedge clk);
        run_burst(b1, 4, 55, 0);
        run_burst(b2, 4, 5, 0);    repeat (2) @(negedge clk);

        // Reset in the middle of a burst: no strobe, then a clean burst
        for (int i = 0; i < 4; i++) begin
            dsi = 1'b1;
            di  = b1[i];
            rank = 4'd4;
            @(negedge clk);
        end
        #1 nrst = 1'b0;
        dsi = 1'b0;
        repeat (2) @(negedge clk);
        #1 nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_nodso", 32'(dso), 32'd0);
        run_burst(b1, 4, 55, 0);   @(negedge clk);

        // Random bursts: mostly full windows, some short/long, narrow value range for ties
        for (int k = 0; k < 300; k++) begin
            int len;
            bit narrow;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 13) : N;
            narrow = $urandom_range(0, 1);
            br.delete();
            for (int j = 0; j < len; j++)
                br.push_back(narrow ? W'($urandom_range(0, 7)) : W'($urandom));
            run_burst(br, $urandom_range(0, 15), -1, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // 3x3 median over a noisy image with edge replication, bursts back-to-back
        for (int y = 0; y < IMG; y++)
            for (int x = 0; x < IMG; x++)
                img[y][x] = W'($urandom);
        for (int y = 0; y < IMG; y++) begin
            for (int x = 0; x < IMG; x++) begin
                br.delete();
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int yy, xx;
                        yy = (y + dy < 0) ? 0 : ((y + dy > IMG - 1) ? IMG - 1 : y + dy);
                        xx = (x + dx < 0) ? 0 : ((x + dx > IMG - 1) ? IMG - 1 : x + dx);
                        br.push_back(img[yy][xx]);
                    end
                end
                run_burst(br, 4, -1, 0);
            end
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
